uart_cmd_rx: RTL and testbench
==============================

// Module: uart_cmd_rx
// PURPOSE
//  UART receiver, 8N1 at clk/CLK_DIV baud, with an ASCII decimal line parser. It accepts lines of
//  four space-separated signed decimal integers terminated by LF, e.g. "  -12   345 0 7\n".
//  Each well-formed line updates o_val0..3 atomically and pulses o_en.
//  Used as the host-side command/setpoint input of the FOC controller.
// PARAMETERS
//  CLK_DIV  16'd217  clk cycles per UART bit, >= 8 (e.g. 25 MHz / 217 = 115200 baud)
// PORTS
//  clk        in   1   clock; single clock domain
//  rst        in   1   synchronous reset, active-high
//  i_uart_rx  in   1   UART RX line, idle high, asynchronous to clk
//  o_val0     out  16  signed, field 0 of last good line
//  o_val1     out  16  signed, field 1 of last good line
//  o_val2     out  16  signed, field 2 of last good line
//  o_val3     out  16  signed, field 3 of last good line
//  o_en       out  1   1-cycle pulse: o_val0..3 updated this cycle
//  o_err      out  1   1-cycle pulse: a malformed line was discarded
// BEHAVIOUR
//  Reset (rst=1 at a clk edge): o_val* = 0, o_en = 0, o_err = 0, both FSMs go idle,
//   accumulators and staging registers cleared. Reset mid-byte or mid-line loses the partial data.
//  Input: i_uart_rx passes through a 2-FF synchronizer, reset to 1; all decoding uses the synced bit.
//  Bit FSM: IDLE -> START -> DATA -> STOP -> IDLE.
//   - IDLE: the synced line falls 1->0 => START, bit counter ccnt = 0.
//   - START: at ccnt = CLK_DIV/2-1, sample the line. 0 => DATA, ccnt = 0. 1 => glitch, back to IDLE.
//   - DATA: sample every CLK_DIV cycles (mid-bit). 8 bits, LSB first, then STOP.
//   - STOP: sample after CLK_DIV cycles. 1 => byte valid pulse, 1 cycle. 0 => framing error pulse.
//     Either way go to IDLE; a new start can be detected from the next cycle.
//  Line parser, driven by byte valid/framing error. States:
//   - FSEP: between fields (initial state).
//   - NEG: a '-' was seen.
//   - DIG: inside a number.
//   - SKIP: error; discard bytes until LF.
//   - 0x0D (CR): ignored in every state.
//   - Framing error: -> SKIP from any state.
//   - '0'..'9':
//     - FSEP or NEG -> DIG, acc = digit.
//     - DIG: acc = min(acc*10 + digit, 32768); acc is 17-bit unsigned, saturating.
//   - '-':
//     - FSEP -> NEG.
//     - Anywhere else -> SKIP.
//   - ' ' (0x20):
//     - DIG: close the field.
//     - FSEP: ignored (runs of spaces collapse).
//     - NEG: -> SKIP.
//   - LF (0x0A):
//     - DIG: close the field, then end the line.
//     - FSEP: end the line.
//     - NEG: error line end.
//     - SKIP: error line end.
//   - Any other byte: -> SKIP.
//  Close field:
//   - Value = neg ? -min(acc, 32768) : min(acc, 32767). Saturates to [-32768, 32767].
//   - Value goes to stage[fcnt]; fcnt++; state -> FSEP.
//   - Closing a 5th field (fcnt == 4) -> SKIP.
//  Line end:
//   - fcnt == 4: o_val0..3 <= stage0..3 and o_en = 1 in the same cycle.
//   - fcnt == 0 and no error: empty line, no pulse.
//   - Otherwise (including SKIP or NEG at LF): o_err = 1, o_val* unchanged.
//   - Afterwards fcnt = 0, acc = 0, neg = 0, state -> FSEP.
//  Latency: o_en/o_err rise exactly 2 clk cycles after the clk edge that samples the LF stop bit.
//  o_en and o_err are never high together. Back-to-back lines need no idle gap.
//  o_val* hold their value between o_en pulses.
// TESTING
//  1. CLK_DIV=217, send "12 -34 567 -8\n" -> one o_en pulse; o_val0..3 = 12, -34, 567, -8; o_err never 1.
//  2. "99999 -99999 32767 -32768\n" -> o_en; values 32767, -32768, 32767, -32768 (saturation).
//  3. "1 2 3\n" then "1 2 3 4 5\n" -> two o_err pulses, no o_en; o_val* keep their prior values.
//  4. "1 x 3 4\n" then "  5   6 7 8\r\n" -> o_err, then o_en with 5, 6, 7, 8; also "\n" alone -> no pulse.
//  5. 50-cycle low glitch on idle rx -> no byte, no pulse.
//     Stop bit forced 0 on "2" of "1 2 3 4\n" -> o_err at LF.
//  6. Assert rst during bit 4 of the '3' in "1 2 3 4\n" -> o_val* = 0, no pulse.
//     Then "9 8 7 6\n" -> o_en with 9, 8, 7, 6; check LF-stop-sample-to-o_en = 2 cycles.

Source files
------------

// File: rtl/uart_cmd_rx.sv
// 8N1 UART receiver feeding an ASCII line parser: four space-separated signed decimals per LF-terminated line.
// A good line updates all four outputs at once and pulses o_en; a malformed line pulses o_err.
module uart_cmd_rx #(
   parameter logic [15:0] CLK_DIV = 16'd217
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               i_uart_rx,
   output logic signed [15:0] o_val0,
   output logic signed [15:0] o_val1,
   output logic signed [15:0] o_val2,
   output logic signed [15:0] o_val3,
   output logic               o_en,
   output logic               o_err
);

   localparam logic [15:0] HALF_M1 = (CLK_DIV >> 1) - 16'd1;
   localparam logic [15:0] FULL_M1 = CLK_DIV - 16'd1;
   localparam logic [7:0]  CH_LF   = 8'h0a;
   localparam logic [7:0]  CH_CR   = 8'h0d;
   localparam logic [7:0]  CH_SP   = 8'h20;
   localparam logic [7:0]  CH_MIN  = 8'h2d;

   typedef enum logic [1:0] {B_IDLE, B_START, B_DATA, B_STOP} bit_state_t;
   typedef enum logic [1:0] {P_FSEP, P_NEG, P_DIG, P_SKIP} parse_state_t;

   logic         rx_s1, rx_s2, rx_d;
   bit_state_t   bstate, b_next;
   logic [15:0]  ccnt, ccnt_n;
   logic [2:0]   bcnt, bcnt_n;
   logic [7:0]   shreg, sh_n;
   logic         byte_vld, vld_n, frame_err, ferr_n;

   parse_state_t pstate, p_next;
   logic [16:0]  acc, acc_n, acc_sat;
   logic [20:0]  acc_mul;
   logic         neg, neg_n, eol, eol_n, en_n, err_n;
   logic [2:0]   fcnt, fcnt_n;
   logic [15:0]  stage [4];
   logic [15:0]  stage_n [4];
   logic [15:0]  val_q [4];
   logic [15:0]  val_n [4];
   logic [15:0]  field_val;
   logic         is_digit;
   logic [3:0]   digit;

   // Bit FSM: a start is a 1->0 fall of the synced line; every sample is taken mid-bit.
   always_comb begin
      b_next = bstate;
      ccnt_n = ccnt + 16'd1;
      bcnt_n = bcnt;
      sh_n   = shreg;
      vld_n  = 1'b0;
      ferr_n = 1'b0;
      case (bstate)
         B_IDLE: begin
            ccnt_n = 16'd0;
            if (!rx_s2 && rx_d) b_next = B_START;
         end
         B_START: if (ccnt == HALF_M1) begin
            ccnt_n = 16'd0;
            bcnt_n = 3'd0;
            b_next = rx_s2 ? B_IDLE : B_DATA;
         end
         B_DATA: if (ccnt == FULL_M1) begin
            ccnt_n = 16'd0;
            sh_n   = {rx_s2, shreg[7:1]};
            bcnt_n = bcnt + 3'd1;
            if (bcnt == 3'd7) b_next = B_STOP;
         end
         default: if (ccnt == FULL_M1) begin
            ccnt_n = 16'd0;
            b_next = B_IDLE;
            vld_n  = rx_s2;
            ferr_n = !rx_s2;
         end
      endcase
   end

   // byte_vld/frame_err are one-cycle strobes with shreg as the payload; the parser has no
   // back-pressure and consumes every strobe in the cycle it is raised.
   assign is_digit  = (shreg >= 8'h30) && (shreg <= 8'h39);
   assign digit     = shreg[3:0];
   assign acc_mul   = 21'(acc) * 21'd10 + 21'(digit);
   assign acc_sat   = (acc_mul > 21'd32768) ? 17'd32768 : acc_mul[16:0];

   always_comb begin
      if (neg) field_val = (acc >= 17'd32768) ? 16'h8000 : (16'd0 - acc[15:0]);
      else     field_val = (acc > 17'd32767) ? 16'h7fff : acc[15:0];
   end

   // LF only raises eol; the line is judged one cycle later, after any closing field has landed.
   always_comb begin
      p_next  = pstate;
      acc_n   = acc;
      neg_n   = neg;
      fcnt_n  = fcnt;
      stage_n = stage;
      val_n   = val_q;
      eol_n   = 1'b0;
      en_n    = 1'b0;
      err_n   = 1'b0;
      if (eol) begin
         if (pstate == P_SKIP || pstate == P_NEG) err_n = 1'b1;
         else if (fcnt == 3'd4) begin
            en_n  = 1'b1;
            val_n = stage;
         end else if (fcnt != 3'd0) err_n = 1'b1;
         p_next = P_FSEP;
         acc_n  = 17'd0;
         neg_n  = 1'b0;
         fcnt_n = 3'd0;
      end else if (frame_err) begin
         p_next = P_SKIP;
      end else if (byte_vld && shreg != CH_CR) begin
         if (is_digit) begin
            if (pstate == P_FSEP || pstate == P_NEG) begin
               p_next = P_DIG;
               acc_n  = {13'd0, digit};
            end else if (pstate == P_DIG) acc_n = acc_sat;
         end else if (shreg == CH_MIN) begin
            if (pstate == P_FSEP) begin
               p_next = P_NEG;
               neg_n  = 1'b1;
            end else p_next = P_SKIP;
         end else if (shreg == CH_SP || shreg == CH_LF) begin
            if (pstate == P_DIG) begin
               if (fcnt == 3'd4) p_next = P_SKIP;
               else begin
                  stage_n[fcnt[1:0]] = field_val;
                  fcnt_n = fcnt + 3'd1;
                  neg_n  = 1'b0;
                  p_next = P_FSEP;
               end
            end else if (pstate == P_NEG && shreg == CH_SP) p_next = P_SKIP;
            eol_n = (shreg == CH_LF);
         end else p_next = P_SKIP;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_s1     <= 1'b1;
         rx_s2     <= 1'b1;
         rx_d      <= 1'b1;
         bstate    <= B_IDLE;
         ccnt      <= 16'd0;
         bcnt      <= 3'd0;
         shreg     <= 8'd0;
         byte_vld  <= 1'b0;
         frame_err <= 1'b0;
         pstate    <= P_FSEP;
         acc       <= 17'd0;
         neg       <= 1'b0;
         fcnt      <= 3'd0;
         eol       <= 1'b0;
         stage     <= '{default: '0};
         val_q     <= '{default: '0};
         o_en      <= 1'b0;
         o_err     <= 1'b0;
      end else begin
         rx_s1     <= i_uart_rx;
         rx_s2     <= rx_s1;
         rx_d      <= rx_s2;
         bstate    <= b_next;
         ccnt      <= ccnt_n;
         bcnt      <= bcnt_n;
         shreg     <= sh_n;
         byte_vld  <= vld_n;
         frame_err <= ferr_n;
         pstate    <= p_next;
         acc       <= acc_n;
         neg       <= neg_n;
         fcnt      <= fcnt_n;
         eol       <= eol_n;
         stage     <= stage_n;
         val_q     <= val_n;
         o_en      <= en_n;
         o_err     <= err_n;
      end
   end

   assign o_val0 = val_q[0];
   assign o_val1 = val_q[1];
   assign o_val2 = val_q[2];
   assign o_val3 = val_q[3];

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Bench for uart_cmd_rx: serial lines are driven bit by bit, a token-level line model predicts each
// line's outcome, and a per-cycle compare process checks pulses and held values against it.
module tb_uart_cmd_rx;

   localparam int D   = 24;
   localparam int H   = D / 2;
   // start-bit drive -> stop-bit sample edge is 3 + H + 9*D (2-FF sync plus fall detect), then 2 more
   localparam int LAT = 5 + H + 9 * D;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic rx  = 1'b1;
   logic signed [15:0] o_val0, o_val1, o_val2, o_val3;
   logic o_en, o_err;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   int last_start_cyc = 0;
   int lf_start_cyc = 0;
   int last_pulse_cyc = -1;
   logic [65:0] exp_q[$];
   logic signed [15:0] exp_v [4];

   uart_cmd_rx #(.CLK_DIV(16'(D))) dut (
      .clk(clk), .rst(rst), .i_uart_rx(rx),
      .o_val0(o_val0), .o_val1(o_val1), .o_val2(o_val2), .o_val3(o_val3),
      .o_en(o_en), .o_err(o_err)
   );

   // clock / reset
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      n_bad++;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $fatal(1, "watchdog");
   end

   // line model: kind 0 = no pulse, 1 = o_en, 2 = o_err; values packed v3..v0
   function automatic logic [65:0] model_line(input string s, input bit ferr);
      int vals [8];
      int ntok = 0;
      bit bad = ferr;
      bit in_tok = 0;
      bit tneg = 0;
      bit first = 0;
      int mag = 0;
      int ndig = 0;
      logic [7:0] c;
      logic [1:0] kind;
      for (int k = 0; k < 8; k++) vals[k] = 0;
      for (int i = 0; i <= s.len(); i++) begin
         c = (i == s.len()) ? 8'h20 : s[i];
         if (c == 8'h0d) continue;
         if (c == 8'h20) begin
            if (in_tok) begin
               if (ndig == 0) bad = 1;
               else if (ntok < 8)
                  vals[ntok] = tneg ? ((mag > 32768) ? -32768 : -mag) : ((mag > 32767) ? 32767 : mag);
               ntok++;
               in_tok = 0;
            end
         end else begin
            if (!in_tok) begin
               in_tok = 1; tneg = 0; mag = 0; ndig = 0; first = 1;
            end
            if (c == 8'h2d && first) tneg = 1;
            else if (c >= 8'h30 && c <= 8'h39) begin
               mag = mag * 10 + (int'(c) - 48);
               if (mag > 99999) mag = 99999;
               ndig++;
            end else bad = 1;
            first = 0;
         end
      end
      if (bad) kind = 2'd2;
      else if (ntok == 0) kind = 2'd0;
      else if (ntok == 4) kind = 2'd1;
      else kind = 2'd2;
      return {kind, 16'(vals[3]), 16'(vals[2]), 16'(vals[1]), 16'(vals[0])};
   endfunction

   // scoreboard compare: pulses are matched against exp_q, held values checked every cycle
   always @(negedge clk) begin
      logic [65:0] e;
      logic [1:0] act;
      if (rst) begin
         exp_q.delete();
         for (int k = 0; k < 4; k++) exp_v[k] = 16'sd0;
      end else begin
         if (o_en && o_err) begin
            n_cmp++; n_bad++;
            $display("FAIL both_pulses: got o_en=1 o_err=1 required at most one");
         end
         if (o_en || o_err) begin
            n_cmp++;
            act = o_en ? 2'd1 : 2'd2;
            if (exp_q.size() == 0) begin
               n_bad++;
               $display("FAIL unexpected_pulse @%0d: got kind %0d required none", cyc, act);
            end else begin
               e = exp_q.pop_front();
               if (act != e[65:64]) begin
                  n_bad++;
                  $display("FAIL pulse_kind @%0d: got %0d required %0d", cyc, act, e[65:64]);
               end
               if (o_en) begin
                  exp_v[0] = e[15:0];  exp_v[1] = e[31:16];
                  exp_v[2] = e[47:32]; exp_v[3] = e[63:48];
                  last_pulse_cyc = cyc;
               end
            end
         end
         n_cmp++;
         if (o_val0 != exp_v[0] || o_val1 != exp_v[1] || o_val2 != exp_v[2] || o_val3 != exp_v[3]) begin
            n_bad++;
            $display("FAIL held_vals @%0d: got %0d %0d %0d %0d required %0d %0d %0d %0d", cyc,
                     o_val0, o_val1, o_val2, o_val3, exp_v[0], exp_v[1], exp_v[2], exp_v[3]);
         end
      end
   end

   // driver tasks
   task automatic check(input string name, input int act, input int req);
      n_cmp++;
      if (act != req) begin
         n_bad++;
         $display("FAIL %s: got %0d required %0d", name, act, req);
      end
   endtask

   task automatic check_vals(input string name, input int a, input int b, input int c, input int d);
      check({name, "_v0"}, int'(o_val0), a);
      check({name, "_v1"}, int'(o_val1), b);
      check({name, "_v2"}, int'(o_val2), c);
      check({name, "_v3"}, int'(o_val3), d);
   endtask

   task automatic send_byte(input logic [7:0] b, input bit bad_stop);
      @(negedge clk);
      rx = 1'b0;
      last_start_cyc = cyc;
      repeat (D) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (D) @(negedge clk);
      end
      rx = ~bad_stop;
      repeat (D) @(negedge clk);
      if (bad_stop) begin
         rx = 1'b1;
         repeat (2 * D) @(negedge clk);
      end
   endtask

   task automatic drain();
      int t = 0;
      while (exp_q.size() != 0 && t < 40 * D) begin
         @(negedge clk);
         t++;
      end
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL pulse_timeout: got %0d pending required 0", exp_q.size());
         exp_q.delete();
      end
      repeat (4) @(negedge clk);
   endtask

   task automatic send_line(input string s, input int ferr_idx);
      logic [65:0] e;
      e = model_line(s, ferr_idx >= 0);
      if (e[65:64] != 2'd0) exp_q.push_back(e);
      for (int i = 0; i < s.len(); i++) send_byte(s[i], i == ferr_idx);
      send_byte(8'h0a, 1'b0);
      lf_start_cyc = last_start_cyc;
      drain();
   endtask

   // directed sequence
   initial begin
      logic [65:0] m;
      logic [7:0] b3;
      b3 = 8'h33;
      rst = 1'b1;
      rx  = 1'b1;
      repeat (4) @(negedge clk);
      #2 rst = 1'b0;
      @(negedge clk);
      check_vals("reset", 0, 0, 0, 0);
      check("reset_en", int'(o_en), 0);
      check("reset_err", int'(o_err), 0);

      m = model_line("12 -34 567 -8", 1'b0);
      check("model_t1", int'(m == {2'd1, 16'hfff8, 16'd567, 16'hffde, 16'd12}), 1);
      m = model_line("99999 -99999 32767 -32768", 1'b0);
      check("model_t2", int'(m == {2'd1, 16'h8000, 16'h7fff, 16'h8000, 16'h7fff}), 1);
      m = model_line("1 2 3", 1'b0);
      check("model_short", int'(m[65:64]), 2);
      m = model_line("", 1'b0);
      check("model_empty", int'(m[65:64]), 0);

      send_line("12 -34 567 -8", -1);
      check_vals("t1", 12, -34, 567, -8);

      send_line("99999 -99999 32767 -32768", -1);
      check_vals("t2", 32767, -32768, 32767, -32768);

      send_line("1 2 3", -1);
      send_line("1 2 3 4 5", -1);
      check_vals("t3", 32767, -32768, 32767, -32768);

      send_line("1 x 3 4", -1);
      send_line("  5   6 7 8\r", -1);
      send_line("", -1);
      check_vals("t4", 5, 6, 7, 8);

      @(negedge clk);
      rx = 1'b0;
      repeat (H - 4) @(negedge clk);
      rx = 1'b1;
      repeat (3 * D) @(negedge clk);
      send_line("1 2 3 4", 2);
      check_vals("t5", 5, 6, 7, 8);

      send_line("7 -0 00032768 -32769", -1);
      check_vals("sat_edge", 7, 0, 32767, -32768);

      send_byte(8'h31, 1'b0);
      send_byte(8'h20, 1'b0);
      send_byte(8'h32, 1'b0);
      send_byte(8'h20, 1'b0);
      @(negedge clk);
      rx = 1'b0;
      repeat (D) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         rx = b3[i];
         repeat (D) @(negedge clk);
      end
      rx = b3[4];
      repeat (H) @(negedge clk);
      #2 rst = 1'b1;
      rx = 1'b1;
      repeat (3) @(negedge clk);
      #2 rst = 1'b0;
      repeat (3 * D) @(negedge clk);
      check_vals("t6_reset", 0, 0, 0, 0);

      send_line("9 8 7 6", -1);
      check_vals("t6", 9, 8, 7, 6);
      check("t6_latency", last_pulse_cyc - lf_start_cyc, LAT);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
